// File: rtl/controller_digest_tx_pkg.sv
// Shared definitions for the Blake2 controller digest return path.
package controller_digest_tx_pkg;

  localparam int DIGEST_WIDTH = 512;
  localparam int DLEN_WIDTH   = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // A length of zero means a full 64-byte digest.
  function automatic logic [DLEN_WIDTH-1:0] eff_len(input logic [DLEN_WIDTH-1:0] len);
    return (len == '0) ? 7'd64 : len;
  endfunction

  // Byte 0 sits in the top byte, so bytes below the length fill from the MSB down.
  function automatic logic [DIGEST_WIDTH-1:0] byte_mask(input logic [DLEN_WIDTH-1:0] len);
    logic [DIGEST_WIDTH-1:0] m;
    logic [DLEN_WIDTH-1:0]   l;
    l = eff_len(len);
    m = '0;
    for (int i = 0; i < DIGEST_WIDTH / 8; i++) begin
      if (7'(i) < l) m[DIGEST_WIDTH-1-8*i -: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/controller_digest_shreg.sv
// Loadable, byte-masked, left-shifting digest register with a word tap at the top.
module controller_digest_shreg
  import controller_digest_tx_pkg::*;
#(
  parameter int proc_bus_width = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      load,
  input  logic                      shift,
  input  logic [DIGEST_WIDTH-1:0]   din,
  input  logic [DLEN_WIDTH-1:0]     len,
  output logic [proc_bus_width-1:0] tap
);

  logic [DIGEST_WIDTH-1:0] shreg_q, shreg_d;

  // Clear wins over load, load wins over shift so a back-to-back capture replaces the last word.
  always_comb begin
    shreg_d = shreg_q;
    if (clear)      shreg_d = '0;
    else if (load)  shreg_d = din & byte_mask(len);
    else if (shift) shreg_d = shreg_q << proc_bus_width;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shreg_q <= '0;
    else          shreg_q <= shreg_d;
  end

  assign tap = shreg_q[DIGEST_WIDTH-1 -: proc_bus_width];

endmodule

// File: rtl/controller_digest_tx.sv
// Captures the engine digest on a rising digest_valid and streams it out word by word.
module controller_digest_tx
  import controller_digest_tx_pkg::*;
#(
  parameter int proc_bus_width = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DIGEST_WIDTH-1:0]   digest,
  input  logic                      digest_valid,
  input  logic [DLEN_WIDTH-1:0]     digest_len,
  input  logic                      new_hash_request,
  output logic [proc_bus_width-1:0] data_out,
  output logic                      valid_out,
  output logic                      last_out,
  input  logic                      ready_in,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CW = $clog2(DIGEST_WIDTH / proc_bus_width) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] words_left_q, words_left_d;
  logic          overrun_q, overrun_d;
  logic          dv_q;
  logic          capture, accept, last_word;
  logic          sh_clear, sh_load, sh_shift;
  logic [10:0]   len_bits;
  logic [10:0]   n_words_full;
  logic [CW-1:0] n_words;

  assign capture   = digest_valid & ~dv_q;
  assign last_word = (words_left_q == CW'(1));
  assign accept    = (state_q == SEND) & ready_in;

  assign len_bits     = {1'b0, eff_len(digest_len), 3'b000};
  assign n_words_full = (len_bits + 11'(proc_bus_width - 1)) / 11'(proc_bus_width);
  assign n_words      = CW'(n_words_full);

  // Abort overrides everything; a capture is only taken when idle or as the last word leaves.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    overrun_d    = overrun_q;
    sh_clear     = 1'b0;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    if (new_hash_request) begin
      state_d      = IDLE;
      words_left_d = '0;
      overrun_d    = 1'b0;
      sh_clear     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            sh_load      = 1'b1;
            words_left_d = n_words;
            state_d      = SEND;
          end
        end
        SEND: begin
          if (accept) begin
            sh_shift     = 1'b1;
            words_left_d = words_left_q - CW'(1);
          end
          if (accept && last_word) begin
            if (capture) begin
              sh_load      = 1'b1;
              words_left_d = n_words;
            end else begin
              state_d = IDLE;
            end
          end else if (capture) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      overrun_q    <= 1'b0;
      dv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      overrun_q    <= overrun_d;
      dv_q         <= digest_valid;
    end
  end

  controller_digest_shreg #(.proc_bus_width(proc_bus_width)) u_shreg (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (sh_clear),
    .load    (sh_load),
    .shift   (sh_shift),
    .din     (digest),
    .len     (digest_len),
    .tap     (data_out)
  );

  assign valid_out = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign last_out  = (state_q == SEND) & last_word;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_controller_digest_tx.sv
// Randomized and directed bench for controller_digest_tx against a word-queue reference model.
module tb_controller_digest_tx;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic [511:0] digest;
  logic         digest_valid;
  logic [6:0]   digest_len;
  logic         new_hash_request;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         last_out;
  logic         ready_in;
  logic         busy;
  logic         overrun;

  int checks;
  int passes;

  logic [W-1:0] mq[$];
  logic         mOverrun;
  logic         mDvPrev;
  logic         mCap, mWasEmpty, mFinishing;

  controller_digest_tx #(.proc_bus_width(W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .digest           (digest),
    .digest_valid     (digest_valid),
    .digest_len       (digest_len),
    .new_hash_request (new_hash_request),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .last_out         (last_out),
    .ready_in         (ready_in),
    .busy             (busy),
    .overrun          (overrun)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
  endtask

  // Expected word stream: each word packs consecutive bytes, bytes past the length read as zero.
  task automatic buildWords(input logic [511:0] d, input logic [6:0] len);
    int L, nW, idx;
    logic [W-1:0] w;
    L  = (len == 7'd0) ? 64 : int'(len);
    nW = (L * 8 + W - 1) / W;
    for (int k = 0; k < nW; k++) begin
      w = '0;
      for (int b = 0; b < W / 8; b++) begin
        idx = k * (W / 8) + b;
        if (idx < L) w[W-1-8*b -: 8] = d[511-8*idx -: 8];
      end
      mq.push_back(w);
    end
  endtask

  // Reference model: a queue of words still owed to the processor plus the sticky overrun flag.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mOverrun = 1'b0;
      mDvPrev  = 1'b0;
    end else begin
      mCap    = digest_valid && !mDvPrev;
      mDvPrev = digest_valid;
      if (new_hash_request) begin
        mq.delete();
        mOverrun = 1'b0;
      end else begin
        mWasEmpty  = (mq.size() == 0);
        mFinishing = !mWasEmpty && ready_in && (mq.size() == 1);
        if (!mWasEmpty && ready_in) void'(mq.pop_front());
        if (mCap) begin
          if (mWasEmpty || mFinishing) buildWords(digest, digest_len);
          else mOverrun = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      checkFlag("valid_out", valid_out, mq.size() != 0);
      checkFlag("busy", busy, mq.size() != 0);
      checkFlag("last_out", last_out, mq.size() == 1);
      checkFlag("overrun", overrun, mOverrun);
      if (mq.size() != 0) checkOutput("data_out", data_out, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic dv, input logic rdy, input logic nhr);
    digest_valid     = dv;
    ready_in         = rdy;
    new_hash_request = nhr;
  endtask

  function automatic logic [511:0] seqDigest();
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[511-8*i -: 8] = 8'(i);
    return d;
  endfunction

  function automatic logic [511:0] randDigest();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Sequential-byte digest with ready high; pins word 4 and its last flag, then idle.
  task automatic runShort(input logic [6:0] len, input logic [W-1:0] expWord4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    digest     = seqDigest();
    digest_len = len;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 4) begin
        checkOutput("short_word4", data_out, expWord4);
        checkFlag("short_last4", last_out, 1'b1);
      end
    end
    step();
    checkFlag("short_idle", valid_out, 1'b0);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset_n = 1'b0;
    digest = '0;
    digest_len = 7'd64;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkFlag("rst_valid", valid_out, 1'b0);
    checkFlag("rst_last", last_out, 1'b0);
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_overrun", overrun, 1'b0);
    checkOutput("rst_data", data_out, '0);
    #21 reset_n = 1'b1;

    // Full 64-byte digest of bytes 0x00..0x3F.
    step();
    digest     = seqDigest();
    digest_len = 7'd64;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] lit;
      step();
      lit = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      checkOutput("t1_word", data_out, lit);
      checkFlag("t1_last", last_out, k == 15);
      if (k == 2) digest_valid = 1'b0;
    end
    step();
    checkFlag("t1_idle", valid_out, 1'b0);

    runShort(7'd20, 32'h10111213);
    runShort(7'd18, 32'h10110000);

    // Stall pattern 1,0,0,1 with length 0 meaning 64 bytes.
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    digest     = randDigest();
    digest_len = 7'd0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 70; k++) begin
      logic [W-1:0] held;
      logic         stalled;
      step();
      if (k > 0 && stalled) checkOutput("stall_stable", data_out, held);
      held    = data_out;
      stalled = valid_out && ((k % 4 == 1) || (k % 4 == 2));
      ready_in = !((k % 4 == 1) || (k % 4 == 2));
    end
    checkFlag("stall_done", valid_out, 1'b0);

    // Overrun: second rising edge at word 3, original digest completes unchanged.
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    digest     = seqDigest();
    digest_len = 7'd64;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 17; k++) begin
      step();
      if (k == 1) digest_valid = 1'b0;
      if (k == 2) begin
        digest_valid = 1'b1;
        digest = randDigest();
      end
      if (k == 5) checkFlag("ovr_set", overrun, 1'b1);
      if (k == 15) checkOutput("ovr_word15", data_out, 32'h3C3D3E3F);
    end
    checkFlag("ovr_sticky", overrun, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step();
    new_hash_request = 1'b0;
    checkFlag("ovr_clear", overrun, 1'b0);

    // Back-to-back: new rising edge coincides with acceptance of the last word.
    step();
    digest     = randDigest();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 1) digest_valid = 1'b0;
      if (k == 15) begin
        digest = seqDigest();
        digest_valid = 1'b1;
      end
    end
    step();
    checkFlag("b2b_valid", valid_out, 1'b1);
    checkOutput("b2b_word0", data_out, 32'h00010203);
    checkFlag("b2b_overrun", overrun, 1'b0);
    for (int k = 0; k < 17; k++) step();
    digest_valid = 1'b0;

    // Abort at word 5 with an overrun pending and a coincident capture that must be dropped.
    step();
    digest = randDigest();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 1) digest_valid = 1'b0;
      if (k == 2) digest_valid = 1'b1;
      if (k == 3) digest_valid = 1'b0;
    end
    checkFlag("abort_pre_ovr", overrun, 1'b1);
    digest = randDigest();
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    new_hash_request = 1'b0;
    checkFlag("abort_valid", valid_out, 1'b0);
    checkFlag("abort_ovr", overrun, 1'b0);
    step();
    checkFlag("abort_nocap", valid_out, 1'b0);
    digest_valid = 1'b0;
    step();
    digest = seqDigest();
    digest_valid = 1'b1;
    step();
    checkOutput("abort_new_w0", data_out, 32'h00010203);
    for (int k = 0; k < 17; k++) step();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      step();
      ready_in = ($urandom_range(0, 3) != 0);
      new_hash_request = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) begin
        digest_valid = ~digest_valid;
        digest       = randDigest();
        digest_len   = 7'($urandom_range(0, 64));
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step();

    // Asynchronous reset mid-transfer.
    digest     = seqDigest();
    digest_len = 7'd64;
    digest_valid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checkFlag("arst_pre_valid", valid_out, 1'b1);
    #1;
    reset_n = 1'b0;
    digest_valid = 1'b0;
    #1;
    checkFlag("arst_valid", valid_out, 1'b0);
    checkFlag("arst_last", last_out, 1'b0);
    checkFlag("arst_busy", busy, 1'b0);
    checkOutput("arst_data", data_out, '0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkFlag("arst_quiet", valid_out, 1'b0);
    end
    digest_valid = 1'b1;
    step();
    checkOutput("arst_recap_w0", data_out, 32'h00010203);
    for (int k = 0; k < 17; k++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/controller_digest_tx.md
# controller_digest_tx

Return-path block of the Blake2 controller: captures the 512-bit digest from the Blake2 hash engine when it becomes valid and streams it back to the processor as `proc_bus_width`-bit words over a valid/ready handshake. It truncates the output to a per-hash digest length in bytes and zero-pads the final word. It is the counterpart of the block-assembly path that feeds `init`/`next`/`block` into the engine.

## Interface
- `proc_bus_width`, 32, processor word width; legal values 8, 16, 32, 64, 128, 256, 512 (must divide 512).
- `clk` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `digest` input 512: engine digest; byte 0 is `digest[511:504]`.
- `digest_valid` input 1: engine level flag; held high while the digest is valid.
- `digest_len` input 7: digest length in bytes, 1..64; 0 is treated as 64; sampled at capture.
- `new_hash_request` input 1: processor abort/restart; flushes any pending output.
- `data_out` output `proc_bus_width`: current digest word.
- `valid_out` output 1: `data_out` is valid.
- `last_out` output 1: current word is the final word of this digest.
- `ready_in` input 1: processor accepts the word.
- `busy` output 1: digest is held or being sent.
- `overrun` output 1: sticky; a new digest arrived while the previous one was still being sent.

## Operation
- Edge detect: register `digest_valid` into `dv_q`. `capture = digest_valid & ~dv_q`.
- Word count: `n_words = ceil(L*8 / proc_bus_width)`, with `L = (digest_len==0) ? 64 : digest_len`, computed at capture and held in a counter of width `clog2(512/proc_bus_width)+1`.
- States:
  - IDLE: `valid_out=0`. On `capture`, load the shift register with `digest`, masked so bytes at index ≥ L are zero. Load `words_left = n_words`. Go to SEND.
  - SEND: `valid_out=1`. `data_out` is the top `proc_bus_width` bits of the shift register. On `valid_out & ready_in`, shift left by `proc_bus_width` and decrement `words_left`. When the word accepted is the one with `words_left==1`, return to IDLE.
- `last_out = (state==SEND) & (words_left==1)`.
- `busy = (state==SEND)`.
- Handshake: while `valid_out & ~ready_in`, `data_out` and `last_out` are held stable. `valid_out` never drops without acceptance, except on abort or reset.
- Boundary conditions:
  - `capture` in SEND while not accepting the last word: the new digest is ignored and `overrun` is set. `overrun` is cleared only by `new_hash_request` or reset.
  - `capture` in the same cycle the last word is accepted: load the new digest and stay in SEND. This is not an overrun.
  - `new_hash_request`: highest priority. Next state is IDLE, `valid_out=0`, `overrun` cleared, shift register zeroed. A `capture` in the same cycle is discarded.
  - `digest_valid` held high across several hashes: only rising edges capture. The engine must drop `digest_valid` between hashes, which it does on `init`.
- Reset (async, any time): state IDLE; `data_out=0`, `valid_out=0`, `last_out=0`, `busy=0`, `overrun=0`, `dv_q=0`, counter 0.

## Timing
- Capture at edge N → `valid_out=1` with word 0 from cycle N+1.
- With `ready_in` held high, one word per cycle. The last word is accepted at cycle N+`n_words`. `valid_out` is 0 from N+`n_words`+1, unless a back-to-back capture occurred.
- Abort: `new_hash_request` sampled at edge M → `valid_out=0` from M+1.
- No combinational path from `ready_in` or `digest_valid` to any output. All outputs are registered or decoded only from state and counter.

## Structure
- Shared package: `DIGEST_WIDTH=512`, `DLEN_WIDTH=7`, state enum {IDLE, SEND}, and the byte-mask function (length → 512-bit mask).
- One natural sub-module, `controller_digest_shreg`: a loadable, masked, left-shifting 512-bit register with `proc_bus_width` output tap. FSM, counter and flags live in the top module.

## Test plan
- W=32, L=64, digest = bytes 0x00..0x3F, `ready_in`=1 → 16 words, 0x00010203 … 0x3C3D3E3F, one per cycle. `last_out` is set only on word 15, at capture+16.
- W=32, L=20 → 5 words. Word 4 = 0x10111213, `last_out=1`. Then W=32, L=18 → word 4 = 0x10110000 (zero pad).
- `ready_in` toggled 1,0,0,1,… → no word lost or duplicated. `data_out` is stable through stalls. L=0 yields 16 words.
- Second `digest_valid` rising edge at word 3 of 16 → `overrun=1`, original 16 words completed unchanged. Second rising edge coincident with last-word acceptance → next digest starts immediately, `overrun=0`.
- `new_hash_request` at word 5 → `valid_out=0` next cycle, `overrun` cleared. A subsequent capture sends the full new digest from word 0.
- `reset_n` asserted asynchronously mid-SEND (between clock edges) → all outputs 0 immediately. After release, IDLE with no output until the next rising edge of `digest_valid`.
